// File: rtl/agen_rep_pipe.sv
// agen_rep_pipe: registered address-generation stage. Forms EA / linear
// address, checks the segment limit at the access size, updates the
// stack/string pointer, and expands REP string micro-ops into one output
// micro-op per iteration.
module agen_rep_pipe #(
  parameter int AW = 32,
  parameter int LW = 20
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_v,
  output logic          o_rdy,
  input  logic [AW-1:0] i_addr1,
  input  logic [AW-1:0] i_addr2,
  input  logic          i_indir,
  input  logic [AW-1:0] i_ptr,
  input  logic [AW-1:0] i_cnt,
  input  logic [1:0]    i_opSize,
  input  logic          i_Dflag,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_str,
  input  logic          i_rep,
  input  logic [AW-1:0] i_seg_base,
  input  logic [LW-1:0] i_limit,
  input  logic          i_inv,
  output logic          o_v,
  input  logic          i_rdy,
  output logic [AW-1:0] o_virt_addr,
  output logic [AW-1:0] o_lin_addr,
  output logic [AW-1:0] o_ptr,
  output logic [AW-1:0] o_cnt,
  output logic          o_fault,
  output logic          o_nop,
  output logic          o_last
);

  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic {IDLE, ITER} st_t;

  typedef struct packed {
    logic [AW-1:0] va;
    logic [AW-1:0] lin;
    logic [AW-1:0] ptr;
    logic [AW-1:0] cnt;
    logic          fault;
    logic          nop;
    logic          last;
  } uop_t;

  st_t           st, st_nx;
  uop_t          q, acc_u, itr_u;
  logic [AW-1:0] seg_q;
  logic [LW-1:0] lim_q;
  logic [2:0]    sz_q;
  logic          df_q;
  logic          acc, adv;
  logic [2:0]    acc_sz;

  function automatic logic [2:0] dec_sz(input logic [1:0] op);
    case (op)
      2'b10:   dec_sz = 3'd2;
      2'b11:   dec_sz = 3'd4;
      default: dec_sz = 3'd1;
    endcase
  endfunction

  // last byte touched, with a carry bit so wrapping past 2^AW also faults
  function automatic logic lim_fault(input logic [AW-1:0] va, input logic [2:0] s,
                                     input logic [LW-1:0] lim);
    logic [AW:0] end_a;
    end_a = {1'b0, va} + {{(AW-2){1'b0}}, s} - {{AW{1'b0}}, 1'b1};
    lim_fault = end_a > {{(AW+1-LW){1'b0}}, lim};
  endfunction

  // micro-op formed from the upstream request (first / only iteration)
  always_comb begin
    logic [AW-1:0] szw;
    logic          rep_str, cnt_zero;
    acc_sz   = dec_sz(i_opSize);
    szw      = {{(AW-3){1'b0}}, acc_sz};
    rep_str  = i_str & i_rep;
    cnt_zero = (i_cnt == '0);
    acc_u     = '0;
    acc_u.va  = i_indir ? i_addr1 + i_addr2 : i_addr1;
    acc_u.ptr = i_ptr;
    acc_u.cnt = i_cnt;
    if (i_push) begin
      acc_u.va  = i_ptr - szw;
      acc_u.ptr = i_ptr - szw;
    end else if (i_pop) begin
      acc_u.va  = i_ptr;
      acc_u.ptr = i_ptr + szw;
    end else if (i_str) begin
      acc_u.va  = i_ptr;
      acc_u.ptr = i_Dflag ? i_ptr - szw : i_ptr + szw;
    end
    if (rep_str && cnt_zero) begin
      acc_u.va  = i_ptr;
      acc_u.ptr = i_ptr;
      acc_u.cnt = '0;
      acc_u.nop = 1'b1;
    end else if (rep_str) begin
      acc_u.cnt = i_cnt - ONE;
    end
    acc_u.fault = ~acc_u.nop & lim_fault(acc_u.va, acc_sz, i_limit);
    acc_u.last  = ~rep_str | cnt_zero | (i_cnt == ONE) | acc_u.fault;
    acc_u.lin   = acc_u.va + i_seg_base;
  end

  // next REP iteration: the pointer/count currently presented are its start values
  always_comb begin
    logic [AW-1:0] szw;
    szw         = {{(AW-3){1'b0}}, sz_q};
    itr_u       = '0;
    itr_u.va    = q.ptr;
    itr_u.ptr   = df_q ? q.ptr - szw : q.ptr + szw;
    itr_u.cnt   = q.cnt - ONE;
    itr_u.fault = lim_fault(q.ptr, sz_q, lim_q);
    itr_u.last  = (itr_u.cnt == '0) | itr_u.fault;
    itr_u.lin   = q.ptr + seg_q;
  end

  // handshake and next-state
  always_comb begin
    st_nx = st;
    o_rdy = (st == IDLE) & (~o_v | i_rdy);
    acc   = i_v & o_rdy;
    adv   = (st == ITER) & o_v & i_rdy;
    if (i_inv)                           st_nx = IDLE;
    else if (acc && i_str && i_rep && !acc_u.last) st_nx = ITER;
    else if (adv && itr_u.last)          st_nx = IDLE;
  end

  // state, output register and per-instruction copies
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st    <= IDLE;
      o_v   <= 1'b0;
      q     <= '0;
      seg_q <= '0;
      lim_q <= '0;
      sz_q  <= '0;
      df_q  <= 1'b0;
    end else begin
      st <= st_nx;
      if (i_inv) begin
        o_v <= 1'b0;
      end else if (acc) begin
        o_v   <= 1'b1;
        q     <= acc_u;
        seg_q <= i_seg_base;
        lim_q <= i_limit;
        sz_q  <= acc_sz;
        df_q  <= i_Dflag;
      end else if (adv) begin
        q <= itr_u;
      end else if (o_v && i_rdy) begin
        o_v <= 1'b0;
      end
    end
  end

  assign o_virt_addr = q.va;
  assign o_lin_addr  = q.lin;
  assign o_ptr       = q.ptr;
  assign o_cnt       = q.cnt;
  assign o_fault     = q.fault;
  assign o_nop       = q.nop;
  assign o_last      = q.last;

endmodule

// File: tb/tb_agen_rep_pipe.sv
// Directed bench for agen_rep_pipe: reset, PUSH/POP/EA forms, limit check,
// REP expansion with backpressure, REP count 0, late fault, flush, hold.
module tb_agen_rep_pipe;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_v, o_rdy;
  logic [31:0] i_addr1, i_addr2, i_ptr, i_cnt, i_seg_base;
  logic        i_indir, i_Dflag, i_push, i_pop, i_str, i_rep, i_inv, i_rdy;
  logic [1:0]  i_opSize;
  logic [19:0] i_limit;
  logic        o_v, o_fault, o_nop, o_last;
  logic [31:0] o_virt_addr, o_lin_addr, o_ptr, o_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  agen_rep_pipe #(.AW(32), .LW(20)) dut (
    .clk(clk), .clr(clr), .i_v(i_v), .o_rdy(o_rdy),
    .i_addr1(i_addr1), .i_addr2(i_addr2), .i_indir(i_indir),
    .i_ptr(i_ptr), .i_cnt(i_cnt), .i_opSize(i_opSize), .i_Dflag(i_Dflag),
    .i_push(i_push), .i_pop(i_pop), .i_str(i_str), .i_rep(i_rep),
    .i_seg_base(i_seg_base), .i_limit(i_limit), .i_inv(i_inv),
    .o_v(o_v), .i_rdy(i_rdy),
    .o_virt_addr(o_virt_addr), .o_lin_addr(o_lin_addr), .o_ptr(o_ptr),
    .o_cnt(o_cnt), .o_fault(o_fault), .o_nop(o_nop), .o_last(o_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic op_clr();
    i_v = 0; i_indir = 0; i_push = 0; i_pop = 0; i_str = 0; i_rep = 0;
    i_Dflag = 0; i_addr1 = 0; i_addr2 = 0; i_ptr = 0; i_cnt = 0; i_opSize = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 0; i_inv = 0; i_rdy = 1; i_seg_base = 0; i_limit = 20'hFFFFF;
    op_clr();

    // reset state
    #3;
    chk1("rst_v", o_v, 1'b0);
    chk1("rst_rdy", o_rdy, 1'b1);
    chk("rst_va", o_virt_addr, 32'h0);
    chk1("rst_last", o_last, 1'b0);
    chk1("rst_fault", o_fault, 1'b0);
    chk1("rst_nop", o_nop, 1'b0);
    #9 clr = 1;

    // PUSH dword
    i_v = 1; i_push = 1; i_ptr = 32'h1000; i_opSize = 2'b11;
    i_seg_base = 32'h20000; i_limit = 20'hFFFFF;
    tick();
    chk1("push_v", o_v, 1'b1);
    chk("push_va", o_virt_addr, 32'hFFC);
    chk("push_lin", o_lin_addr, 32'h20FFC);
    chk("push_ptr", o_ptr, 32'hFFC);
    chk1("push_fault", o_fault, 1'b0);
    chk1("push_last", o_last, 1'b1);

    // limit: dword at 0xFFFF faults, then byte back-to-back does not
    op_clr(); i_v = 1; i_indir = 1; i_addr1 = 32'hFFFE; i_addr2 = 32'h1;
    i_opSize = 2'b11; i_seg_base = 0; i_limit = 20'h0FFFF;
    tick();
    chk("lim4_va", o_virt_addr, 32'hFFFF);
    chk1("lim4_fault", o_fault, 1'b1);
    chk1("lim4_last", o_last, 1'b1);
    chk1("lim4_rdy", o_rdy, 1'b1);
    i_opSize = 2'b00;
    tick();
    chk1("lim1_v", o_v, 1'b1);
    chk1("lim1_fault", o_fault, 1'b0);

    // POP word, then plain non-indirect EA
    op_clr(); i_v = 1; i_pop = 1; i_ptr = 32'h2000; i_opSize = 2'b10; i_limit = 20'hFFFFF;
    tick();
    chk("pop_va", o_virt_addr, 32'h2000);
    chk("pop_ptr", o_ptr, 32'h2002);
    op_clr(); i_v = 1; i_addr1 = 32'h345; i_addr2 = 32'h1000; i_ptr = 32'h55;
    i_cnt = 32'h7; i_seg_base = 32'h100;
    tick();
    chk("ea_va", o_virt_addr, 32'h345);
    chk("ea_lin", o_lin_addr, 32'h445);
    chk("ea_ptr", o_ptr, 32'h55);
    chk("ea_cnt", o_cnt, 32'h7);
    op_clr();
    tick();
    chk1("drain_v", o_v, 1'b0);

    // REP MOVS word, count 3, Dflag=1, ready 1,0,1,1
    i_v = 1; i_str = 1; i_rep = 1; i_ptr = 32'h100; i_cnt = 3; i_Dflag = 1;
    i_opSize = 2'b10; i_seg_base = 32'h1000;
    tick();
    op_clr(); i_seg_base = 0;
    chk("rep1_va", o_virt_addr, 32'h100);
    chk("rep1_cnt", o_cnt, 32'h2);
    chk1("rep1_last", o_last, 1'b0);
    chk1("rep1_rdy", o_rdy, 1'b0);
    tick();
    chk("rep2_va", o_virt_addr, 32'hFE);
    chk("rep2_cnt", o_cnt, 32'h1);
    chk1("rep2_last", o_last, 1'b0);
    chk1("rep2_rdy", o_rdy, 1'b0);
    i_rdy = 0;
    tick();
    chk("rep2h_va", o_virt_addr, 32'hFE);
    chk1("rep2h_rdy", o_rdy, 1'b0);
    i_rdy = 1;
    tick();
    chk("rep3_va", o_virt_addr, 32'hFC);
    chk("rep3_lin", o_lin_addr, 32'h10FC);
    chk("rep3_cnt", o_cnt, 32'h0);
    chk1("rep3_last", o_last, 1'b1);
    chk1("rep3_rdy", o_rdy, 1'b1);
    tick();
    chk1("rep_done_v", o_v, 1'b0);

    // REP count 0: nop, never faults even outside the limit
    i_v = 1; i_str = 1; i_rep = 1; i_ptr = 32'h500; i_cnt = 0; i_opSize = 2'b11;
    i_limit = 20'h10;
    tick();
    op_clr();
    chk1("rep0_nop", o_nop, 1'b1);
    chk1("rep0_last", o_last, 1'b1);
    chk("rep0_ptr", o_ptr, 32'h500);
    chk("rep0_cnt", o_cnt, 32'h0);
    chk1("rep0_fault", o_fault, 1'b0);
    chk1("rep0_rdy", o_rdy, 1'b1);
    tick();

    // fault on the second iteration terminates the REP
    i_v = 1; i_str = 1; i_rep = 1; i_ptr = 32'h100; i_cnt = 3; i_opSize = 2'b11;
    i_limit = 20'h103;
    tick();
    op_clr();
    chk1("rf1_fault", o_fault, 1'b0);
    chk1("rf1_last", o_last, 1'b0);
    tick();
    chk("rf2_va", o_virt_addr, 32'h104);
    chk1("rf2_fault", o_fault, 1'b1);
    chk1("rf2_last", o_last, 1'b1);
    chk1("rf2_rdy", o_rdy, 1'b1);
    tick();
    chk1("rf_done_v", o_v, 1'b0);
    i_limit = 20'hFFFFF;

    // flush on the 2nd of 4 byte iterations
    i_v = 1; i_str = 1; i_rep = 1; i_ptr = 32'h200; i_cnt = 4; i_opSize = 2'b00;
    tick();
    op_clr();
    tick();
    chk("fl2_va", o_virt_addr, 32'h201);
    chk("fl2_cnt", o_cnt, 32'h2);
    i_inv = 1;
    tick();
    i_inv = 0;
    chk1("fl_v", o_v, 1'b0);
    chk1("fl_rdy", o_rdy, 1'b1);
    i_v = 1; i_push = 1; i_ptr = 32'h3000; i_opSize = 2'b10;
    tick();
    chk1("flnx_v", o_v, 1'b1);
    chk("flnx_va", o_virt_addr, 32'h2FFE);
    chk1("flnx_last", o_last, 1'b1);

    // hold under backpressure, then overwrite on simultaneous drain + accept
    op_clr(); i_v = 1; i_pop = 1; i_ptr = 32'h4000; i_opSize = 2'b10; i_rdy = 0;
    #1;
    chk1("hold_rdy", o_rdy, 1'b0);
    tick();
    chk("hold_va", o_virt_addr, 32'h2FFE);
    chk1("hold_v", o_v, 1'b1);
    i_rdy = 1;
    #1;
    chk1("ovw_rdy", o_rdy, 1'b1);
    tick();
    chk("ovw_va", o_virt_addr, 32'h4000);
    chk("ovw_ptr", o_ptr, 32'h4002);

    // flush discards a same-cycle accept
    op_clr(); i_v = 1; i_push = 1; i_ptr = 32'h8000; i_opSize = 2'b11; i_inv = 1;
    tick();
    i_inv = 0; op_clr();
    chk1("invacc_v", o_v, 1'b0);

    // asynchronous reset in the middle of a REP
    i_v = 1; i_str = 1; i_rep = 1; i_ptr = 32'h600; i_cnt = 5; i_opSize = 2'b11;
    tick();
    op_clr();
    chk1("mr_v_pre", o_v, 1'b1);
    #2 clr = 0;
    #1;
    chk1("mr_v", o_v, 1'b0);
    chk1("mr_rdy", o_rdy, 1'b1);
    #2 clr = 1;
    i_v = 1; i_indir = 1; i_addr1 = 32'h10; i_addr2 = 32'h20; i_ptr = 32'h77; i_cnt = 9;
    tick();
    op_clr();
    chk1("mr_nx_v", o_v, 1'b1);
    chk("mr_nx_va", o_virt_addr, 32'h30);
    chk("mr_nx_cnt", o_cnt, 32'h9);
    chk1("mr_nx_last", o_last, 1'b1);
    tick();
    chk1("mr_end_v", o_v, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
